// File: rtl/uart_cfg_pkg.sv
// uart_cfg_pkg: shared widths, dispatcher FSM state type and UART defaults.
package uart_cfg_pkg;
    localparam int NUM_MOD = 6;
    localparam int ADR_W   = 2;
    localparam int DAT_W   = 24;
    // Queue entry layout, MSB first: {trp, mod_sel, adress, d}.
    localparam int ENTRY_W = 33;
    // Default UART bit period, shared so the receiver and this block agree.
    localparam int BPS_CNT = 434;
    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_ISSUE,
        S_TRIG
    } state_e;
endpackage

// File: rtl/cfg_cmd_fifo.sv
// cfg_cmd_fifo: synchronous command FIFO with level count.
// Ports: clk_i/rst_ni clock and async active-low reset; push_i/wdata_i write side;
// pop_i/rdata_o read side (rdata_o shows the head); full_o, empty_o, level_o status.
module cfg_cmd_fifo #(
    parameter int W     = 33,
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [W-1:0]             wdata_i,
    output logic [W-1:0]             rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [AW:0]   cnt_q;
    logic          do_push, do_pop;
    assign full_o  = cnt_q == (AW+1)'(DEPTH);
    assign empty_o = cnt_q == '0;
    assign do_pop  = pop_i && !empty_o;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_push = push_i && (!full_o || do_pop);
    assign rdata_o = mem_q[rptr_q];
    assign level_o = cnt_q;
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q] <= wdata_i;
    end
    // Pointers are AW bits wide so they wrap modulo DEPTH on their own.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + AW'(1);
            if (do_pop)  rptr_q <= rptr_q + AW'(1);
            cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/uart_cfg_dispatch.sv
// uart_cfg_dispatch: queues received config commands and replays each as per-module writes.
// Ports: sys_clk/sys_rst clock and async active-low reset; cmd_* one-cycle command strobe
// from the receiver; wr_* valid/ready write bus, one module per transfer; trig timed pulse
// after a command's writes; busy, fifo_level, cmd_overflow, timeout_err status.
module uart_cfg_dispatch
    import uart_cfg_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int TRP_PULSE = 4,
    parameter int TIMEOUT   = 1024
) (
    input  logic                       sys_clk,
    input  logic                       sys_rst,
    input  logic                       cmd_valid,
    input  logic [ADR_W-1:0]           cmd_adress,
    input  logic [NUM_MOD-1:0]         cmd_mod_sel,
    input  logic [DAT_W-1:0]           cmd_d,
    input  logic                       cmd_trp,
    output logic                       wr_valid,
    output logic [NUM_MOD-1:0]         wr_sel,
    output logic [ADR_W-1:0]           wr_adress,
    output logic [DAT_W-1:0]           wr_data,
    input  logic [NUM_MOD-1:0]         wr_ready,
    output logic                       trig,
    output logic                       busy,
    output logic [$clog2(DEPTH):0]     fifo_level,
    output logic                       cmd_overflow,
    output logic                       timeout_err
);
    localparam int IW = $clog2(NUM_MOD);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int PW = $clog2(TRP_PULSE + 1);
    function automatic logic [IW-1:0] lsb_idx(input logic [NUM_MOD-1:0] v);
        lsb_idx = '0;
        for (int i = NUM_MOD - 1; i >= 0; i--) if (v[i]) lsb_idx = IW'(i);
    endfunction
    state_e               state_q;
    logic                 trp_q;
    logic [NUM_MOD-1:0]   pend_q;
    logic [ADR_W-1:0]     adr_q;
    logic [DAT_W-1:0]     dat_q;
    logic [TW-1:0]        timer_q;
    logic [PW-1:0]        pcnt_q;
    logic [ENTRY_W-1:0]   fifo_rd;
    logic                 fifo_full, fifo_empty, pop, hit;
    assign pop  = state_q == S_IDLE && !fifo_empty;
    assign busy = !fifo_empty || state_q != S_IDLE;
    // wr_sel is one-hot during ISSUE, so this samples only the addressed module's ready.
    assign hit  = |(wr_ready & wr_sel);
    cfg_cmd_fifo #(.W(ENTRY_W), .DEPTH(DEPTH)) u_fifo (
        .clk_i   (sys_clk),
        .rst_ni  (sys_rst),
        .push_i  (cmd_valid),
        .pop_i   (pop),
        .wdata_i ({cmd_trp, cmd_mod_sel, cmd_adress, cmd_d}),
        .rdata_o (fifo_rd),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level)
    );
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            state_q      <= S_IDLE;
            trp_q        <= 1'b0;
            pend_q       <= '0;
            adr_q        <= '0;
            dat_q        <= '0;
            timer_q      <= '0;
            pcnt_q       <= '0;
            wr_valid     <= 1'b0;
            wr_sel       <= '0;
            wr_adress    <= '0;
            wr_data      <= '0;
            trig         <= 1'b0;
            cmd_overflow <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            cmd_overflow <= cmd_valid && fifo_full && !pop;
            timeout_err  <= 1'b0;
            case (state_q)
                S_IDLE: if (pop) begin
                    {trp_q, pend_q, adr_q, dat_q} <= fifo_rd;
                    state_q <= S_SCAN;
                end
                S_SCAN: if (pend_q == '0) begin
                    state_q <= trp_q ? S_TRIG : S_IDLE;
                    trig    <= trp_q;
                    pcnt_q  <= '0;
                end else begin
                    wr_valid  <= 1'b1;
                    wr_sel    <= NUM_MOD'(1) << lsb_idx(pend_q);
                    wr_adress <= adr_q;
                    wr_data   <= dat_q;
                    timer_q   <= '0;
                    state_q   <= S_ISSUE;
                end
                // Bus outputs stay frozen here until the module accepts or the wait expires.
                S_ISSUE: if (hit || timer_q == TW'(TIMEOUT - 1)) begin
                    timeout_err <= !hit;
                    pend_q      <= pend_q & ~wr_sel;
                    wr_valid    <= 1'b0;
                    wr_sel      <= '0;
                    wr_adress   <= '0;
                    wr_data     <= '0;
                    state_q     <= S_SCAN;
                end else begin
                    timer_q <= timer_q + TW'(1);
                end
                S_TRIG: if (pcnt_q == PW'(TRP_PULSE - 1)) begin
                    trig    <= 1'b0;
                    state_q <= S_IDLE;
                end else begin
                    pcnt_q <= pcnt_q + PW'(1);
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_cfg_dispatch.sv
// tb_uart_cfg_dispatch: table-driven and directed checks of the config command dispatcher.
module tb_uart_cfg_dispatch;
    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b0;
    logic        cmd_valid = 1'b0;
    logic [1:0]  cmd_adress = '0;
    logic [5:0]  cmd_mod_sel = '0;
    logic [23:0] cmd_d = '0;
    logic        cmd_trp = 1'b0;
    logic [5:0]  wr_ready = '0;
    logic        wr_valid, trig, busy, cmd_overflow, timeout_err;
    logic [5:0]  wr_sel;
    logic [1:0]  wr_adress;
    logic [23:0] wr_data;
    logic [2:0]  fifo_level;
    int checks = 0;
    int passed = 0;
    int hold, terr, m5, ovf, lmax, nwv, nbusy;
    logic [23:0] seen [$];
    logic [23:0] ord [5];
    typedef struct packed {
        logic        cv;
        logic [5:0]  ms;
        logic [1:0]  adr;
        logic [23:0] d;
        logic        trp;
        logic        wv;
        logic [5:0]  sel;
        logic        tg;
        logic        bz;
        logic [2:0]  lv;
    } vec_t;
    vec_t tbl [27];
    always #5 sys_clk = ~sys_clk;
    uart_cfg_dispatch #(.DEPTH(4), .TRP_PULSE(4), .TIMEOUT(16)) dut (
        .sys_clk      (sys_clk),
        .sys_rst      (sys_rst),
        .cmd_valid    (cmd_valid),
        .cmd_adress   (cmd_adress),
        .cmd_mod_sel  (cmd_mod_sel),
        .cmd_d        (cmd_d),
        .cmd_trp      (cmd_trp),
        .wr_valid     (wr_valid),
        .wr_sel       (wr_sel),
        .wr_adress    (wr_adress),
        .wr_data      (wr_data),
        .wr_ready     (wr_ready),
        .trig         (trig),
        .busy         (busy),
        .fifo_level   (fifo_level),
        .cmd_overflow (cmd_overflow),
        .timeout_err  (timeout_err)
    );
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask
    function automatic vec_t mk(input logic cv, input logic [5:0] ms, input logic [1:0] adr,
                                input logic [23:0] d, input logic trp, input logic wv,
                                input logic [5:0] sel, input logic tg, input logic bz,
                                input logic [2:0] lv);
        mk = '{cv, ms, adr, d, trp, wv, sel, tg, bz, lv};
    endfunction
    task automatic drive(input logic cv, input logic [5:0] ms, input logic [1:0] adr,
                         input logic [23:0] d, input logic trp);
        cmd_valid   = cv;
        cmd_mod_sel = ms;
        cmd_adress  = adr;
        cmd_d       = d;
        cmd_trp     = trp;
    endtask
    initial begin
        // Outputs are checked at step i before that step's inputs are applied.
        tbl[0]  = mk(1, 6'h25, 2'd2, 24'hA5A5A5, 0,  0, 6'h00, 0, 0, 3'd0);
        tbl[1]  = mk(0, 6'h00, 2'd0, 24'h0,      0,  0, 6'h00, 0, 1, 3'd1);
        tbl[2]  = mk(0, 6'h00, 2'd0, 24'h0,      0,  0, 6'h00, 0, 1, 3'd0);
        tbl[3]  = mk(0, 6'h00, 2'd0, 24'h0,      0,  1, 6'h01, 0, 1, 3'd0);
        tbl[4]  = mk(0, 6'h00, 2'd0, 24'h0,      0,  0, 6'h00, 0, 1, 3'd0);
        tbl[5]  = mk(0, 6'h00, 2'd0, 24'h0,      0,  1, 6'h04, 0, 1, 3'd0);
        tbl[6]  = mk(0, 6'h00, 2'd0, 24'h0,      0,  0, 6'h00, 0, 1, 3'd0);
        tbl[7]  = mk(0, 6'h00, 2'd0, 24'h0,      0,  1, 6'h20, 0, 1, 3'd0);
        tbl[8]  = mk(0, 6'h00, 2'd0, 24'h0,      0,  0, 6'h00, 0, 1, 3'd0);
        tbl[9]  = mk(1, 6'h25, 2'd2, 24'hA5A5A5, 1,  0, 6'h00, 0, 0, 3'd0);
        tbl[10] = mk(0, 6'h00, 2'd0, 24'h0,      0,  0, 6'h00, 0, 1, 3'd1);
        tbl[11] = mk(0, 6'h00, 2'd0, 24'h0,      0,  0, 6'h00, 0, 1, 3'd0);
        tbl[12] = mk(0, 6'h00, 2'd0, 24'h0,      0,  1, 6'h01, 0, 1, 3'd0);
        tbl[13] = mk(0, 6'h00, 2'd0, 24'h0,      0,  0, 6'h00, 0, 1, 3'd0);
        tbl[14] = mk(0, 6'h00, 2'd0, 24'h0,      0,  1, 6'h04, 0, 1, 3'd0);
        tbl[15] = mk(0, 6'h00, 2'd0, 24'h0,      0,  0, 6'h00, 0, 1, 3'd0);
        tbl[16] = mk(0, 6'h00, 2'd0, 24'h0,      0,  1, 6'h20, 0, 1, 3'd0);
        tbl[17] = mk(0, 6'h00, 2'd0, 24'h0,      0,  0, 6'h00, 0, 1, 3'd0);
        tbl[18] = mk(0, 6'h00, 2'd0, 24'h0,      0,  0, 6'h00, 1, 1, 3'd0);
        tbl[19] = mk(0, 6'h00, 2'd0, 24'h0,      0,  0, 6'h00, 1, 1, 3'd0);
        tbl[20] = mk(0, 6'h00, 2'd0, 24'h0,      0,  0, 6'h00, 1, 1, 3'd0);
        tbl[21] = mk(0, 6'h00, 2'd0, 24'h0,      0,  0, 6'h00, 1, 1, 3'd0);
        tbl[22] = mk(1, 6'h00, 2'd3, 24'hFFFFFF, 0,  0, 6'h00, 0, 0, 3'd0);
        tbl[23] = mk(0, 6'h00, 2'd0, 24'h0,      0,  0, 6'h00, 0, 1, 3'd1);
        tbl[24] = mk(0, 6'h00, 2'd0, 24'h0,      0,  0, 6'h00, 0, 1, 3'd0);
        tbl[25] = mk(0, 6'h00, 2'd0, 24'h0,      0,  0, 6'h00, 0, 0, 3'd0);
        tbl[26] = mk(0, 6'h00, 2'd0, 24'h0,      0,  0, 6'h00, 0, 0, 3'd0);
        ord = '{24'h100001, 24'h100002, 24'h100003, 24'h100004, 24'h100006};
        #12;
        chk("reset outputs", 64'({wr_valid, wr_sel, wr_adress, wr_data, trig, busy,
                                  fifo_level, cmd_overflow, timeout_err}), 64'(0));
        @(negedge sys_clk);
        sys_rst  = 1'b1;
        wr_ready = 6'h3F;
        for (int i = 0; i < 27; i++) begin
            @(negedge sys_clk);
            chk($sformatf("t%0d wr_valid", i), 64'(wr_valid), 64'(tbl[i].wv));
            chk($sformatf("t%0d wr_sel", i), 64'(wr_sel), 64'(tbl[i].sel));
            chk($sformatf("t%0d trig", i), 64'(trig), 64'(tbl[i].tg));
            chk($sformatf("t%0d busy", i), 64'(busy), 64'(tbl[i].bz));
            chk($sformatf("t%0d fifo_level", i), 64'(fifo_level), 64'(tbl[i].lv));
            chk($sformatf("t%0d cmd_overflow", i), 64'(cmd_overflow), 64'(0));
            chk($sformatf("t%0d timeout_err", i), 64'(timeout_err), 64'(0));
            if (tbl[i].wv) begin
                chk($sformatf("t%0d wr_adress", i), 64'(wr_adress), 64'(2));
                chk($sformatf("t%0d wr_data", i), 64'(wr_data), 64'(24'hA5A5A5));
            end
            drive(tbl[i].cv, tbl[i].ms, tbl[i].adr, tbl[i].d, tbl[i].trp);
        end
        // Module 2 never answers: its write is held for TIMEOUT cycles, then module 5 follows.
        wr_ready = 6'b111011;
        @(negedge sys_clk);
        drive(1, 6'h25, 2'd1, 24'h00C0DE, 0);
        @(negedge sys_clk);
        drive(0, 6'h00, 2'd0, 24'h0, 0);
        hold = 0; terr = 0; m5 = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge sys_clk);
            if (wr_valid && wr_sel == 6'h04 && wr_data == 24'h00C0DE) hold++;
            if (timeout_err) terr++;
            if (wr_valid && wr_sel == 6'h20) m5++;
        end
        chk("timeout hold cycles", 64'(hold), 64'(16));
        chk("timeout_err pulses", 64'(terr), 64'(1));
        chk("module 5 written after timeout", 64'(m5), 64'(1));
        chk("idle after timeout", 64'(busy), 64'(0));
        // Six back-to-back strobes with the bus stalled: one popped, four queued, one dropped.
        wr_ready = 6'h00;
        ovf = 0; lmax = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge sys_clk);
            if (cmd_overflow) ovf++;
            if (int'(fifo_level) > lmax) lmax = int'(fifo_level);
            if (k < 6) drive(1, 6'h01, 2'(k), 24'h100000 + 24'(k), 0);
            else drive(0, 6'h00, 2'd0, 24'h0, 0);
        end
        chk("overflow pulses", 64'(ovf), 64'(1));
        chk("fifo_level peak", 64'(lmax), 64'(4));
        chk("first command issuing", 64'({wr_valid, wr_data}), 64'({1'b1, 24'h100000}));
        wr_ready = 6'h01;
        @(negedge sys_clk);
        chk("scan after accept", 64'(wr_valid), 64'(0));
        @(negedge sys_clk);
        chk("full before push+pop", 64'(fifo_level), 64'(4));
        drive(1, 6'h01, 2'd2, 24'h100006, 0);
        @(negedge sys_clk);
        drive(0, 6'h00, 2'd0, 24'h0, 0);
        chk("push+pop level", 64'(fifo_level), 64'(4));
        chk("push+pop no overflow", 64'(cmd_overflow), 64'(0));
        for (int k = 0; k < 40; k++) begin
            @(negedge sys_clk);
            if (wr_valid) seen.push_back(wr_data);
        end
        chk("drained write count", 64'(seen.size()), 64'(5));
        for (int j = 0; j < 5; j++)
            chk($sformatf("order %0d", j), 64'(j < seen.size() ? seen[j] : 24'h0), 64'(ord[j]));
        // Reset in the middle of a stalled write with one command still queued.
        wr_ready = 6'h00;
        @(negedge sys_clk);
        drive(1, 6'h02, 2'd1, 24'h0BEEF0, 0);
        @(negedge sys_clk);
        drive(1, 6'h02, 2'd1, 24'h0BEEF1, 0);
        @(negedge sys_clk);
        drive(0, 6'h00, 2'd0, 24'h0, 0);
        @(negedge sys_clk);
        chk("pre-reset issue", 64'({wr_valid, wr_sel, fifo_level}), 64'({1'b1, 6'h02, 3'd1}));
        #2 sys_rst = 1'b0;
        #1;
        chk("async reset bus", 64'({wr_valid, wr_sel, wr_adress, wr_data}), 64'(0));
        chk("async reset status", 64'({trig, busy, fifo_level, cmd_overflow, timeout_err}), 64'(0));
        @(negedge sys_clk);
        sys_rst  = 1'b1;
        wr_ready = 6'h3F;
        nwv = 0; nbusy = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge sys_clk);
            if (wr_valid) nwv++;
            if (busy) nbusy++;
        end
        chk("no replay after reset", 64'(nwv), 64'(0));
        chk("idle after reset", 64'(nbusy), 64'(0));
        drive(1, 6'h02, 2'd3, 24'h00FACE, 0);
        @(negedge sys_clk);
        drive(0, 6'h00, 2'd0, 24'h0, 0);
        nwv = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge sys_clk);
            if (wr_valid && wr_sel == 6'h02 && wr_data == 24'h00FACE) nwv++;
        end
        chk("write after reset", 64'(nwv), 64'(1));
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/uart_cfg_dispatch.md
Name: uart_cfg_dispatch

Overview:
Command scheduler that sits behind the UART receive path. It queues each decoded configuration command (address, module-select mask, 24-bit data, trigger flag) and replays it as one write transaction per selected module, lowest module index first. After the last write of a command it emits a timed trigger pulse if the command requested one. It converts the receiver's single-cycle "received_done" burst interface into a paced, per-module valid/ready write bus.

Parameters:
DEPTH, 4, command FIFO depth in entries; power of two, at least 2.
TRP_PULSE, 4, trigger pulse width in sys_clk cycles; at least 1.
TIMEOUT, 1024, maximum cycles wr_valid may wait for a module's ready before the write is abandoned.

Ports:
sys_clk  in  1  system clock.
sys_rst  in  1  asynchronous, active-low reset.
cmd_valid  in  1  one-cycle strobe; connects to received_done.
cmd_adress  in  2  register address within the target module.
cmd_mod_sel  in  6  module-select bitmask; bit i selects module i.
cmd_d  in  24  write data.
cmd_trp  in  1  request a trigger pulse after all writes of this command.
wr_valid  out  1  write request valid.
wr_sel  out  6  one-hot target module; all zero when wr_valid=0.
wr_adress  out  2  address of the current write.
wr_data  out  24  data of the current write.
wr_ready  in  6  per-module ready; bit i is sampled only when wr_sel[i]=1.
trig  out  1  trigger output.
busy  out  1  high when the FIFO is non-empty or the FSM is not in IDLE.
fifo_level  out  $clog2(DEPTH)+1  number of queued commands.
cmd_overflow  out  1  one-cycle pulse when a command is dropped because the FIFO is full.
timeout_err  out  1  one-cycle pulse when a write is abandoned on timeout.

Behaviour:
- Reset (sys_rst=0, asynchronous):
  - All outputs go to 0.
  - The FIFO is emptied and the FSM returns to IDLE.
  - Reset asserted mid-transaction aborts the transaction; nothing is replayed after reset.
- FIFO:
  - Each entry is 33 bits: {trp, mod_sel, adress, d}.
  - A push occurs on cmd_valid when the FIFO is not full, or when it is full and a pop happens in the same cycle.
  - Otherwise the command is dropped, cmd_overflow pulses for one cycle, and fifo_level is unchanged.
  - Read and write pointers wrap modulo DEPTH.
- FSM states: IDLE, SCAN, ISSUE, TRIG.
  - IDLE: if the FIFO is non-empty, pop the head into working registers, set pending := mod_sel, and go to SCAN.
  - SCAN:
    - If pending==0: go to TRIG if trp=1, else to IDLE.
    - Otherwise set idx := lowest set bit of pending, clear the timer, and go to ISSUE.
  - ISSUE:
    - Outputs: wr_valid=1, wr_sel=one-hot(idx), wr_adress and wr_data from the working registers.
    - If wr_ready[idx]=1: the transfer completes this cycle; clear pending[idx] and go to SCAN.
    - Else if timer==TIMEOUT-1: pulse timeout_err, clear pending[idx], and go to SCAN.
    - Else increment the timer.
  - TRIG: trig=1 for exactly TRP_PULSE cycles (counter), then go to IDLE.
- Outputs are registered. wr_valid and wr_sel must not change while in ISSUE until completion or timeout.
- Latency: with cmd_valid in cycle 0, an empty FIFO and the FSM in IDLE, wr_valid rises in cycle 3.
- Spacing: consecutive writes of one command are separated by one SCAN cycle (wr_valid low for 1 cycle).
- A command with mod_sel=0 and trp=0 is consumed with no bus activity; IDLE is re-entered 2 cycles after the pop.
- A command with mod_sel=0 and trp=1 produces only the trigger pulse.
- Commands execute strictly in FIFO order. Commands never interleave.

Decomposition:
- Shared package uart_cfg_pkg holds:
  - localparams NUM_MOD=6, ADR_W=2, DAT_W=24, ENTRY_W=33;
  - the FSM state enum;
  - the default BPS_CNT=434, so the top level and this block agree.
- One sub-module: cfg_cmd_fifo, a parameterised synchronous FIFO with push/pop, full/empty and level.
- Lowest-set-bit priority encoding stays in this module as a function.

Test Plan:
1. Single command: mod_sel=6'b100101, adress=2, d=24'hA5A5A5, trp=0; wr_ready tied to all-ones → writes to modules 0, 2, 5 in that order; first wr_valid in cycle 3; each write lasts 1 cycle with 1 idle cycle between writes; no trig pulse.
2. Trigger: same command with trp=1 and TRP_PULSE=4 → trig rises the cycle after the last SCAN and stays high exactly 4 cycles; busy=0 afterwards.
3. Backpressure/timeout: wr_ready[2] held at 0 with TIMEOUT=16 → wr_valid held stable for 16 cycles; timeout_err pulses once; module 5 is still written.
4. Overflow: 6 cmd_valid strobes on consecutive cycles while wr_ready=0 (DEPTH=4) → first command popped, 4 queued, 1 dropped; exactly one cmd_overflow pulse; fifo_level peaks at 4.
5. Simultaneous push/pop while full: cmd_valid in the same cycle the FSM pops from a full FIFO → command accepted; no cmd_overflow; fifo_level stays at 4.
6. Reset mid-ISSUE: assert sys_rst low while wr_valid=1 → all outputs 0 immediately (asynchronously), fifo_level=0; after release, no writes occur until a new cmd_valid arrives.
